tlda_pixel_write_fifo: RTL and testbench
========================================

Name: tlda_pixel_write_fifo

Overview:
Elastic pixel-write buffer between the thick-line-draw peripheral's Avalon master and the pixel-buffer memory. It accepts 16-bit pixel writes on an Avalon-MM slave port and queues address, byteenable and data in order. It replays them on an Avalon-MM master, decoupling the line engine from memory stalls. It also reports occupancy and an idle flag, so software can tell when the last pixel of a line has actually reached memory, not just when the draw completes.

Parameters:
DEPTH, 16, total entries including the master output register; power of 2, at least 2
ADDR_W, 32, pixel address width
DATA_W, 16, pixel data width; byteenable width is DATA_W/8
LVL_W, 5, occupancy width; must equal log2(DEPTH)+1

Ports:
csi_clockreset_clk  in  1  clock; all state on the rising edge
csi_clockreset_resetn  in  1  asynchronous, active-low reset
avs_slave_write  in  1  pixel write request from upstream master
avs_slave_address  in  ADDR_W  pixel byte address
avs_slave_writedata  in  DATA_W  pixel colour
avs_slave_byteenable  in  DATA_W/8  byte lanes
avs_slave_waitrequest  out  1  high means the write is not accepted this cycle
avm_master_write  out  1  write request to memory
avm_master_address  out  ADDR_W  queued address
avm_master_writedata  out  DATA_W  queued data
avm_master_byteenable  out  DATA_W/8  queued byte lanes
avm_master_waitrequest  in  1  memory stall
clear_count  in  1  synchronous clear of pixel_count
fifo_level  out  LVL_W  entries held, including the output register (0..DEPTH)
fifo_idle  out  1  high when fifo_level is 0
pixel_count  out  32  writes completed on the master since reset or clear

Behaviour:
- Reset (async, resetn=0):
  - all entries are discarded; any in-flight master write is abandoned.
  - avm_master_write=0; master address, data and byteenable=0.
  - avs_slave_waitrequest=0, fifo_level=0, fifo_idle=1, pixel_count=0.
- Slave accept:
  - a write is accepted when avs_slave_write=1 and avs_slave_waitrequest=0.
  - avs_slave_waitrequest = (fifo_level==DEPTH). It is decoded from registered state only, with no combinational path from avm_master_waitrequest.
  - when full, a same-cycle master pop does not lower waitrequest in that cycle.
- Zero byteenable:
  - an accepted write with byteenable=0 is dropped.
  - it is not queued and not counted, and fifo_level is unchanged.
- Master side:
  - the output register holds the head entry; avm_master_write=1 while it is valid.
  - address, data and byteenable stay stable while avm_master_waitrequest=1.
  - a write completes when avm_master_write=1 and avm_master_waitrequest=0.
  - on completion, the next edge loads the next entry if one exists; otherwise avm_master_write drops to 0.
  - back-to-back completions sustain one write per cycle.
- Latency:
  - when the block is empty, a write accepted in cycle n appears with avm_master_write=1 in cycle n+1 (fall-through into the output register).
  - this is also the case when the output register is completing in cycle n and the storage FIFO is empty.
- Ordering: strict FIFO; no reordering or merging of writes to the same address.
- Level update: +1 per accepted non-zero-byteenable write, -1 per master completion; simultaneous accept and completion leaves it unchanged.
- Storage:
  - DEPTH-1 entry circular buffer plus the output register.
  - read and write pointers wrap modulo DEPTH-1 (implementer may size the RAM to DEPTH and cap the level).
  - no overflow or underflow is possible by construction.
- pixel_count:
  - +1 per master completion; wraps at 2^32.
  - clear_count alone gives 0 at the next edge.
  - clear_count together with a completion gives 1.
- fifo_idle is registered together with fifo_level and is exact (no lag relative to fifo_level).

Test Plan:
- Reset then single write (addr 0x0800_0010, data 0xF800, be 2'b11), master waitrequest=0 -> avm_master_write high exactly one cycle, one cycle after accept, fields identical; level returns to 0 and pixel_count=1.
- Hold avm_master_waitrequest=1 and push 20 writes with DEPTH=16 -> 16 accepted; avs_slave_waitrequest=1 from the cycle level hits 16; master outputs stable throughout; release -> 16 writes in order, one per cycle, idle afterwards.
- Continuous push with waitrequest toggling 1,0,1,0 -> output sequence matches input order exactly; level never exceeds 16 or goes below 0.
- Write with be=2'b00 between two valid writes -> accepted without stall; only 2 master writes occur; pixel_count=2.
- Assert clear_count in the same cycle as a master completion with pixel_count=7 -> pixel_count=1 next cycle.
- Assert resetn=0 mid-burst with 9 entries queued and master stalled -> avm_master_write=0 and level 0 immediately (async); after release, no stale writes are issued.

Source files
------------

// File: rtl/tlda_pixel_write_fifo.sv
// Elastic pixel-write buffer: Avalon-MM slave in, Avalon-MM master out.
// Handshake: the slave side transfers on avs_slave_write & ~avs_slave_waitrequest;
// the master side transfers on avm_master_write & ~avm_master_waitrequest.
// Entries are held in a circular buffer plus one master output register.
// Occupancy counts both, so fifo_idle means the last pixel reached memory.
module tlda_pixel_write_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int LVL_W  = 5
) (
  input  logic                csi_clockreset_clk,
  input  logic                csi_clockreset_resetn,
  input  logic                avs_slave_write,
  input  logic [ADDR_W-1:0]   avs_slave_address,
  input  logic [DATA_W-1:0]   avs_slave_writedata,
  input  logic [DATA_W/8-1:0] avs_slave_byteenable,
  output logic                avs_slave_waitrequest,
  output logic                avm_master_write,
  output logic [ADDR_W-1:0]   avm_master_address,
  output logic [DATA_W-1:0]   avm_master_writedata,
  output logic [DATA_W/8-1:0] avm_master_byteenable,
  input  logic                avm_master_waitrequest,
  input  logic                clear_count,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                fifo_idle,
  output logic [31:0]         pixel_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W + BE_W;

  // The RAM is sized DEPTH so pointers wrap naturally; mem_cnt never
  // exceeds DEPTH-1 because the output register holds the remaining entry.
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] mem_cnt, level_q;
  logic             idle_q;
  logic             out_valid;
  logic [ENT_W-1:0] out_ent;

  logic             accept, complete, out_free, mem_has;
  logic             pop, bypass, push;
  logic [ENT_W-1:0] in_ent;
  logic [LVL_W-1:0] level_next, mem_cnt_next;

  // Full is decoded from the registered level only, so memory stalls never
  // reach the slave waitrequest combinationally.
  assign avs_slave_waitrequest = (level_q == LVL_W'(DEPTH));

  assign avm_master_write = out_valid;
  assign {avm_master_address, avm_master_writedata, avm_master_byteenable} = out_ent;
  assign fifo_level = level_q;
  assign fifo_idle  = idle_q;

  // Transfer decode: zero-byteenable writes are acknowledged but dropped.
  always_comb begin
    in_ent       = {avs_slave_address, avs_slave_writedata, avs_slave_byteenable};
    accept       = avs_slave_write & ~avs_slave_waitrequest & (|avs_slave_byteenable);
    complete     = out_valid & ~avm_master_waitrequest;
    out_free     = ~out_valid | complete;
    mem_has      = (mem_cnt != '0);
    pop          = out_free & mem_has;
    bypass       = out_free & ~mem_has & accept;
    push         = accept & ~bypass;
    level_next   = level_q + LVL_W'(accept) - LVL_W'(complete);
    mem_cnt_next = mem_cnt + LVL_W'(push) - LVL_W'(pop);
  end

  // Storage array write port; contents need no reset since mem_cnt gates reads.
  always_ff @(posedge csi_clockreset_clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  // Pointers, counts and the master output register.
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_resetn) begin
    if (!csi_clockreset_resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      level_q   <= '0;
      idle_q    <= 1'b1;
      out_valid <= 1'b0;
      out_ent   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt_next;
      level_q <= level_next;
      idle_q  <= (level_next == '0);
      if (out_free) begin
        if (mem_has) begin
          out_valid <= 1'b1;
          out_ent   <= mem[rd_ptr];
        end else if (accept) begin
          out_valid <= 1'b1;
          out_ent   <= in_ent;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Completed-write counter; a clear coinciding with a completion yields 1.
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_resetn) begin
    if (!csi_clockreset_resetn) begin
      pixel_count <= '0;
    end else if (clear_count) begin
      pixel_count <= {31'd0, complete};
    end else begin
      pixel_count <= pixel_count + 32'(complete);
    end
  end

endmodule

// File: tb/tb_tlda_pixel_write_fifo.sv
// Directed bench for tlda_pixel_write_fifo with a reference queue of expected
// master writes and a cycle-level occupancy/counter model.
module tb_tlda_pixel_write_fifo;

  logic        clk;
  logic        rst_n;
  logic        s_write;
  logic [31:0] s_addr;
  logic [15:0] s_data;
  logic [1:0]  s_be;
  logic        s_wait;
  logic        m_write;
  logic [31:0] m_addr;
  logic [15:0] m_data;
  logic [1:0]  m_be;
  logic        m_wait;
  logic        clear;
  logic [4:0]  level;
  logic        idle;
  logic [31:0] pcount;

  int vectors     = 0;
  int miscompares = 0;
  int mdl_lvl     = 0;
  logic [31:0] mdl_cnt = '0;
  logic [49:0] exp_q[$];

  tlda_pixel_write_fifo dut (
    .csi_clockreset_clk     (clk),
    .csi_clockreset_resetn  (rst_n),
    .avs_slave_write        (s_write),
    .avs_slave_address      (s_addr),
    .avs_slave_writedata    (s_data),
    .avs_slave_byteenable   (s_be),
    .avs_slave_waitrequest  (s_wait),
    .avm_master_write       (m_write),
    .avm_master_address     (m_addr),
    .avm_master_writedata   (m_data),
    .avm_master_byteenable  (m_be),
    .avm_master_waitrequest (m_wait),
    .clear_count            (clear),
    .fifo_level             (level),
    .fifo_idle              (idle),
    .pixel_count            (pcount)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check pre-edge outputs against the model, advance the model
  // with the inputs presented at this edge, then check post-edge state.
  task automatic cyc();
    logic comp, acc;
    check("slave_waitreq", 64'(s_wait), 64'(mdl_lvl == 16));
    check("master_write", 64'(m_write), 64'(mdl_lvl != 0));
    if (mdl_lvl != 0 && exp_q.size() != 0)
      check("master_fields", 64'({m_addr, m_data, m_be}), 64'(exp_q[0]));
    comp = (mdl_lvl != 0) && !m_wait;
    acc  = s_write && (mdl_lvl != 16) && (s_be != 2'b00);
    @(posedge clk);
    #1;
    if (comp && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({s_addr, s_data, s_be});
    mdl_lvl = mdl_lvl + (acc ? 1 : 0) - (comp ? 1 : 0);
    mdl_cnt = clear ? 32'(comp) : mdl_cnt + 32'(comp);
    check("fifo_level", 64'(level), 64'(mdl_lvl));
    check("fifo_idle", 64'(idle), 64'(mdl_lvl == 0));
    check("pixel_count", 64'(pcount), 64'(mdl_cnt));
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [15:0] d, input logic [1:0] b);
    s_write = w;
    s_addr  = a;
    s_data  = d;
    s_be    = b;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && mdl_lvl != 0; k++) cyc();
    check("drained_idle", 64'(idle), 64'd1);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    clear = 1'b0;
    m_wait = 1'b0;
    drive(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_master_write", 64'(m_write), 64'd0);
    check("rst_master_fields", 64'({m_addr, m_data, m_be}), 64'd0);
    check("rst_slave_waitreq", 64'(s_wait), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_pixel_count", 64'(pcount), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Single write: visible one cycle after accept for exactly one cycle.
    drive(1'b1, 32'h0800_0010, 16'hF800, 2'b11);
    cyc();
    drive(1'b0, '0, '0, '0);
    check("single_write_up", 64'(m_write), 64'd1);
    check("single_fields", 64'({m_addr, m_data, m_be}), 64'({32'h0800_0010, 16'hF800, 2'b11}));
    cyc();
    check("single_write_down", 64'(m_write), 64'd0);
    check("single_level", 64'(level), 64'd0);
    check("single_count", 64'(pcount), 64'd1);
    cyc();

    // Fill under a memory stall: 16 of 20 accepted, then release and drain.
    m_wait = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(2 * i), 16'(16'h0111 * i), 2'b11);
      cyc();
    end
    drive(1'b0, '0, '0, '0);
    check("full_level", 64'(level), 64'd16);
    check("full_waitreq", 64'(s_wait), 64'd1);
    m_wait = 1'b0;
    for (int i = 0; i < 17; i++) cyc();
    check("burst_idle", 64'(idle), 64'd1);

    // Continuous push with the memory stall toggling.
    for (int i = 0; i < 24; i++) begin
      m_wait = (i % 2 == 0);
      drive(1'b1, 32'h0000_2000 + 32'(2 * i), 16'hA500 ^ 16'(i), 2'(i % 3 + 1));
      cyc();
    end
    drive(1'b0, '0, '0, '0);
    for (int k = 0; k < 100 && mdl_lvl != 0; k++) begin
      m_wait = ~m_wait;
      cyc();
    end
    check("toggle_idle", 64'(idle), 64'd1);
    m_wait = 1'b0;

    // Zero-byteenable write is acknowledged without stall and dropped.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_alone", 64'(pcount), 64'd0);
    drive(1'b1, 32'h0000_3000, 16'h1234, 2'b01);
    cyc();
    drive(1'b1, 32'h0000_3002, 16'hDEAD, 2'b00);
    check("zero_be_no_stall", 64'(s_wait), 64'd0);
    cyc();
    drive(1'b1, 32'h0000_3004, 16'h5678, 2'b10);
    cyc();
    drive(1'b0, '0, '0, '0);
    drain();
    check("zero_be_count", 64'(pcount), 64'd2);

    // Bring count to 7, then clear in the same cycle as a completion.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000_4000 + 32'(2 * i), 16'(16'h0F0F + i), 2'b11);
      cyc();
    end
    drive(1'b0, '0, '0, '0);
    drain();
    m_wait = 1'b1;
    drive(1'b1, 32'h0000_5000, 16'h07E0, 2'b11);
    cyc();
    drive(1'b0, '0, '0, '0);
    cyc();
    check("count_before_clear", 64'(pcount), 64'd7);
    clear = 1'b1;
    m_wait = 1'b0;
    cyc();
    clear = 1'b0;
    check("clear_with_completion", 64'(pcount), 64'd1);

    // Asynchronous reset mid-burst with 9 entries queued and memory stalled.
    m_wait = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h0000_6000 + 32'(2 * i), 16'(16'h3300 + i), 2'b11);
      cyc();
    end
    drive(1'b0, '0, '0, '0);
    check("pre_reset_level", 64'(level), 64'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_write", 64'(m_write), 64'd0);
    check("async_rst_level", 64'(level), 64'd0);
    check("async_rst_idle", 64'(idle), 64'd1);
    check("async_rst_count", 64'(pcount), 64'd0);
    mdl_lvl = 0;
    mdl_cnt = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    m_wait = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    drive(1'b1, 32'h0000_7000, 16'hBEEF, 2'b11);
    cyc();
    drive(1'b0, '0, '0, '0);
    drain();
    check("post_reset_count", 64'(pcount), 64'd1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
